// File: rtl/pickup_pkg.sv
// Shared constants and FSM encoding for the pickup array unit.
package pickup_pkg;

    localparam int MAX_PICKUPS = 16;
    localparam int CNT_W       = 11;  // VGA counters
    localparam int POS_W       = 12;  // object coordinates
    localparam int CMP_W       = 13;  // coordinate + extent, cannot wrap

    localparam logic [11:0] DEFAULT_RGB = 12'hFF0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } scan_state_e;

endpackage

// File: rtl/pickup_box_hit.sv
// Strict overlap test of box A (A_W x A_H) against box B (B_W x B_H).
// A 1x1 box A turns this into the point-in-box test used for rendering.
module pickup_box_hit
    import pickup_pkg::*;
#(
    parameter int A_W = 1,
    parameter int A_H = 1,
    parameter int B_W = 16,
    parameter int B_H = 16
) (
    input  logic [POS_W-1:0] a_x_i,
    input  logic [POS_W-1:0] a_y_i,
    input  logic [POS_W-1:0] b_x_i,
    input  logic [POS_W-1:0] b_y_i,
    output logic             hit_o
);

    logic [CMP_W-1:0] ax, ay, bx, by;

    assign ax = {1'b0, a_x_i};
    assign ay = {1'b0, a_y_i};
    assign bx = {1'b0, b_x_i};
    assign by = {1'b0, b_y_i};

    // Touching edges do not count as overlap.
    assign hit_o = (ax < bx + CMP_W'(B_W)) && (bx < ax + CMP_W'(A_W)) &&
                   (ay < by + CMP_W'(B_H)) && (by < ay + CMP_W'(A_H));

endmodule

// File: rtl/pickup_array_unit.sv
// Draws N fixed pickups into the VGA stream and scores hero overlap once per frame.
// Optional blinking of drawn pickups is enabled by defining PICKUP_BLINK_EN.
module pickup_array_unit
    import pickup_pkg::*;
#(
    parameter int                      N_PICKUPS  = 5,
    parameter logic [N_PICKUPS*24-1:0] PICKUP_POS = '0,
    parameter int                      PICKUP_W   = 16,
    parameter int                      PICKUP_H   = 16,
    parameter int                      HERO_W     = 32,
    parameter int                      HERO_H     = 32,
    parameter logic [11:0]             PICKUP_RGB = DEFAULT_RGB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] hcount_in,
    input  logic             hsync_in,
    input  logic             hblnk_in,
    input  logic [CNT_W-1:0] vcount_in,
    input  logic             vsync_in,
    input  logic             vblnk_in,
    input  logic [11:0]      rgb_in,
    input  logic [POS_W-1:0] hero_x_pos,
    input  logic [POS_W-1:0] hero_y_pos,
    input  logic             respawn,
    output logic [CNT_W-1:0] hcount_out,
    output logic             hsync_out,
    output logic             hblnk_out,
    output logic [CNT_W-1:0] vcount_out,
    output logic             vsync_out,
    output logic             vblnk_out,
    output logic [11:0]      rgb_out,
    output logic [7:0]       score,
    output logic             collected,
    output logic             level_clear
);

    localparam int IDX_W = (N_PICKUPS > 1) ? $clog2(N_PICKUPS) : 1;

    scan_state_e          state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_PICKUPS-1:0] alive_q, alive_d;
    logic [7:0]           score_q, score_d;
    logic                 collected_q, collected_d;
    logic [POS_W-1:0]     hero_x_q, hero_x_d, hero_y_q, hero_y_d;
    logic                 level_clear_q;
    logic [11:0]          rgb_q, rgb_d;

    logic [POS_W-1:0]     pos_x [N_PICKUPS];
    logic [POS_W-1:0]     pos_y [N_PICKUPS];
    logic [N_PICKUPS-1:0] pix_in_box;
    logic                 scan_overlap, scan_hit, vblnk_rise, blink_on, draw;

    for (genvar i = 0; i < N_PICKUPS; i++) begin : g_pickup
        assign pos_x[i] = PICKUP_POS[i*24+12 +: 12];
        assign pos_y[i] = PICKUP_POS[i*24    +: 12];

        pickup_box_hit #(.A_W(1), .A_H(1), .B_W(PICKUP_W), .B_H(PICKUP_H)) u_render (
            .a_x_i ({1'b0, hcount_in}),
            .a_y_i ({1'b0, vcount_in}),
            .b_x_i (pos_x[i]),
            .b_y_i (pos_y[i]),
            .hit_o (pix_in_box[i])
        );
    end

    pickup_box_hit #(.A_W(HERO_W), .A_H(HERO_H), .B_W(PICKUP_W), .B_H(PICKUP_H)) u_scan (
        .a_x_i (hero_x_q),
        .a_y_i (hero_y_q),
        .b_x_i (pos_x[idx_q]),
        .b_y_i (pos_y[idx_q]),
        .hit_o (scan_overlap)
    );

    // The delayed vblnk output doubles as the previous-cycle sample for edge detect.
    assign vblnk_rise = vblnk_in & ~vblnk_out;
    assign scan_hit   = (state_q == ST_SCAN) && alive_q[idx_q] && scan_overlap;

`ifdef PICKUP_BLINK_EN
    logic [5:0] frame_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             frame_cnt_q <= '0;
        else if (vblnk_rise) frame_cnt_q <= frame_cnt_q + 6'd1;
    end

    assign blink_on = ~frame_cnt_q[5];
`else
    assign blink_on = 1'b1;
`endif

    assign draw  = |(pix_in_box & alive_q) & ~hblnk_in & ~vblnk_in & blink_on;
    assign rgb_d = draw ? PICKUP_RGB : rgb_in;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        alive_d     = alive_q;
        score_d     = score_q;
        collected_d = 1'b0;
        hero_x_d    = hero_x_q;
        hero_y_d    = hero_y_q;

        case (state_q)
            ST_IDLE: begin
                if (vblnk_rise) begin
                    state_d  = ST_SCAN;
                    idx_d    = '0;
                    hero_x_d = hero_x_pos;
                    hero_y_d = hero_y_pos;
                end
            end
            ST_SCAN: begin
                if (scan_hit) begin
                    alive_d[idx_q] = 1'b0;
                    collected_d    = 1'b1;
                    if (score_q != 8'hFF) score_d = score_q + 8'd1;
                end
                if (idx_q == IDX_W'(N_PICKUPS - 1)) state_d = ST_DONE;
                else                                idx_d   = idx_q + 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Respawn overrides any hit being scored this cycle.
        if (respawn) begin
            state_d     = ST_IDLE;
            idx_d       = '0;
            alive_d     = '1;
            score_d     = score_q;
            collected_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            alive_q       <= '1;
            score_q       <= '0;
            collected_q   <= 1'b0;
            level_clear_q <= 1'b0;
            hero_x_q      <= '0;
            hero_y_q      <= '0;
            rgb_q         <= '0;
            hcount_out    <= '0;
            hsync_out     <= 1'b0;
            hblnk_out     <= 1'b0;
            vcount_out    <= '0;
            vsync_out     <= 1'b0;
            vblnk_out     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            alive_q       <= alive_d;
            score_q       <= score_d;
            collected_q   <= collected_d;
            level_clear_q <= ~|alive_d;
            hero_x_q      <= hero_x_d;
            hero_y_q      <= hero_y_d;
            rgb_q         <= rgb_d;
            hcount_out    <= hcount_in;
            hsync_out     <= hsync_in;
            hblnk_out     <= hblnk_in;
            vcount_out    <= vcount_in;
            vsync_out     <= vsync_in;
            vblnk_out     <= vblnk_in;
        end
    end

    assign rgb_out     = rgb_q;
    assign score       = score_q;
    assign collected   = collected_q;
    assign level_clear = level_clear_q;

endmodule
